// File: rtl/hw_sw_frame_sync_if.sv
// Software/hardware frame-sync bus: command, ten capture words and frame pulse in;
// ack/toggle, committed object words, busy and frame count out.
interface hw_sw_frame_sync_if;
  logic [1:0]  to_hw_sig;
  logic [31:0] to_hw_port0;
  logic [31:0] to_hw_port1;
  logic [31:0] to_hw_port2;
  logic [31:0] to_hw_port3;
  logic [31:0] to_hw_port4;
  logic [31:0] to_hw_port5;
  logic [31:0] to_hw_port6;
  logic [31:0] to_hw_port7;
  logic [31:0] to_hw_port8;
  logic [31:0] to_hw_port9;
  logic        frame_start;

  logic [1:0]  to_sw_sig;
  logic [31:0] obj_word0;
  logic [31:0] obj_word1;
  logic [31:0] obj_word2;
  logic [31:0] obj_word3;
  logic [31:0] obj_word4;
  logic [31:0] obj_word5;
  logic [31:0] obj_word6;
  logic [31:0] obj_word7;
  logic [31:0] obj_word8;
  logic [31:0] obj_word9;
  logic        busy;
  logic [15:0] frame_count;

  modport master (
    output to_hw_sig,
    output to_hw_port0, to_hw_port1, to_hw_port2, to_hw_port3, to_hw_port4,
    output to_hw_port5, to_hw_port6, to_hw_port7, to_hw_port8, to_hw_port9,
    output frame_start,
    input  to_sw_sig,
    input  obj_word0, obj_word1, obj_word2, obj_word3, obj_word4,
    input  obj_word5, obj_word6, obj_word7, obj_word8, obj_word9,
    input  busy,
    input  frame_count
  );

  modport slave (
    input  to_hw_sig,
    input  to_hw_port0, to_hw_port1, to_hw_port2, to_hw_port3, to_hw_port4,
    input  to_hw_port5, to_hw_port6, to_hw_port7, to_hw_port8, to_hw_port9,
    input  frame_start,
    output to_sw_sig,
    output obj_word0, obj_word1, obj_word2, obj_word3, obj_word4,
    output obj_word5, obj_word6, obj_word7, obj_word8, obj_word9,
    output busy,
    output frame_count
  );
endinterface

// File: rtl/hw_sw_frame_sync.sv
// Captures ten software-written words into a staging buffer (optionally aligned to
// vertical blank) and commits them to the draw-side shadow registers on a single edge.
module hw_sw_frame_sync #(
  parameter int unsigned SYNC_TO_FRAME = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  hw_sw_frame_sync_if.slave  bus
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_FRAME = 3'd1;
  localparam logic [2:0] COPY       = 3'd2;
  localparam logic [2:0] CLEAR      = 3'd3;
  localparam logic [2:0] COMMIT     = 3'd4;
  localparam logic [2:0] ACK        = 3'd5;

  localparam logic [1:0] SIG_IDLE  = 2'b00;
  localparam logic [1:0] SIG_POST  = 2'b01;
  localparam logic [1:0] SIG_CLEAR = 2'b10;

  localparam logic [3:0] LAST_IDX = 4'd9;

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        ack_q, ack_d;
  logic        tog_q;
  logic [15:0] fcnt_q;

  logic [31:0] port_w    [10];
  logic [31:0] staging_q [10];
  logic [31:0] obj_q     [10];

  logic        stage_we;
  logic        commit_en;
  logic [31:0] stage_data;
  logic [31:0] port_sel;

  assign port_w[0] = bus.to_hw_port0;
  assign port_w[1] = bus.to_hw_port1;
  assign port_w[2] = bus.to_hw_port2;
  assign port_w[3] = bus.to_hw_port3;
  assign port_w[4] = bus.to_hw_port4;
  assign port_w[5] = bus.to_hw_port5;
  assign port_w[6] = bus.to_hw_port6;
  assign port_w[7] = bus.to_hw_port7;
  assign port_w[8] = bus.to_hw_port8;
  assign port_w[9] = bus.to_hw_port9;

  always_comb begin
    port_sel = '0;
    for (int k = 0; k < 10; k++) begin
      if (idx_q == 4'(k)) port_sel = port_w[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ack_d      = ack_q;
    stage_we   = 1'b0;
    stage_data = '0;
    commit_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.to_hw_sig == SIG_POST) begin
          state_d = (SYNC_TO_FRAME != 0) ? WAIT_FRAME : COPY;
          idx_d   = '0;
        end else if (bus.to_hw_sig == SIG_CLEAR) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      WAIT_FRAME: begin
        // Software withdrawing the post wins over a coincident frame pulse.
        if (bus.to_hw_sig == SIG_IDLE) begin
          state_d = IDLE;
        end else if (bus.frame_start) begin
          state_d = COPY;
          idx_d   = '0;
        end
      end
      COPY, CLEAR: begin
        stage_we   = 1'b1;
        stage_data = (state_q == COPY) ? port_sel : '0;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      COMMIT: begin
        commit_en = 1'b1;
        ack_d     = 1'b1;
        state_d   = ACK;
      end
      ACK: begin
        if (bus.to_hw_sig == SIG_IDLE) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < 10; k++) staging_q[k] <= '0;
    end else if (stage_we) begin
      for (int k = 0; k < 10; k++) begin
        if (idx_q == 4'(k)) staging_q[k] <= stage_data;
      end
    end
  end

  // All ten shadow words load together so the draw side never sees a mixed set.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < 10; k++) obj_q[k] <= '0;
    end else if (commit_en) begin
      for (int k = 0; k < 10; k++) obj_q[k] <= staging_q[k];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fcnt_q <= '0;
      tog_q  <= 1'b0;
    end else if (bus.frame_start) begin
      fcnt_q <= fcnt_q + 16'd1;
      tog_q  <= ~tog_q;
    end
  end

  assign bus.to_sw_sig   = {tog_q, ack_q};
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_count = fcnt_q;

  assign bus.obj_word0 = obj_q[0];
  assign bus.obj_word1 = obj_q[1];
  assign bus.obj_word2 = obj_q[2];
  assign bus.obj_word3 = obj_q[3];
  assign bus.obj_word4 = obj_q[4];
  assign bus.obj_word5 = obj_q[5];
  assign bus.obj_word6 = obj_q[6];
  assign bus.obj_word7 = obj_q[7];
  assign bus.obj_word8 = obj_q[8];
  assign bus.obj_word9 = obj_q[9];

endmodule

// File: tb/tb_hw_sw_frame_sync.sv
// Scoreboard bench for hw_sw_frame_sync: stimulus pushes expected commits, a monitor
// pops and compares them whenever the ack bit rises.
module tb_hw_sw_frame_sync;

  typedef logic [9:0][31:0] words_t;
  typedef struct packed {
    words_t      words;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int          n_chk;
  int          n_fail;
  logic [15:0] fc_model;
  logic        tog_model;
  exp_t        sb_q[$];

  hw_sw_frame_sync_if bus ();

  hw_sw_frame_sync #(.SYNC_TO_FRAME(1)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic words_t mkwords(input logic [31:0] base);
    words_t w;
    for (int k = 0; k < 10; k++) w[k] = base + 32'(k);
    return w;
  endfunction

  function automatic words_t cur_words();
    return {bus.obj_word9, bus.obj_word8, bus.obj_word7, bus.obj_word6, bus.obj_word5,
            bus.obj_word4, bus.obj_word3, bus.obj_word2, bus.obj_word1, bus.obj_word0};
  endfunction

  task automatic set_ports(input logic [31:0] base);
    bus.to_hw_port0 = base + 32'd0;
    bus.to_hw_port1 = base + 32'd1;
    bus.to_hw_port2 = base + 32'd2;
    bus.to_hw_port3 = base + 32'd3;
    bus.to_hw_port4 = base + 32'd4;
    bus.to_hw_port5 = base + 32'd5;
    bus.to_hw_port6 = base + 32'd6;
    bus.to_hw_port7 = base + 32'd7;
    bus.to_hw_port8 = base + 32'd8;
    bus.to_hw_port9 = base + 32'd9;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int unsigned t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_timeout: cycle %0d target %0d", cyc, t);
    end
  endtask

  // Called at a negedge; returns the cycle number of the edge that sampled the pulse.
  task automatic pulse_frame(output int unsigned e);
    bus.frame_start = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    @(negedge clk);
    bus.frame_start = 1'b0;
    fc_model  = fc_model + 16'd1;
    tog_model = ~tog_model;
  endtask

  task automatic issue_sig(input logic [1:0] sig, output int unsigned e);
    bus.to_hw_sig = sig;
    @(posedge clk);
    #1;
    e = cyc;
    @(negedge clk);
  endtask

  task automatic expect_commit(input words_t w, input int unsigned c);
    exp_t ex;
    ex.words = w;
    ex.cyc   = c;
    sb_q.push_back(ex);
  endtask

  // Monitor: every ack rise must match a queued commit; no other word change is legal.
  words_t prev_words;
  logic   prev_ack;
  logic   prev_rst;
  initial begin
    prev_words = '0;
    prev_ack   = 1'b0;
    prev_rst   = 1'b1;
  end

  always @(negedge clk) begin
    exp_t ex;
    if (!rst && !prev_rst) begin
      if (bus.to_sw_sig[0] && !prev_ack) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_commit: ack rose at cycle %0d with nothing expected", cyc);
        end else begin
          ex = sb_q.pop_front();
          check("commit_words", cur_words(), ex.words);
          check("commit_cycle", 320'(cyc), 320'(ex.cyc));
        end
      end else if (cur_words() !== prev_words) begin
        n_chk++;
        n_fail++;
        $display("FAIL stray_word_update: words %0h changed without ack at cycle %0d",
                 cur_words(), cyc);
      end
    end
    prev_words = cur_words();
    prev_ack   = bus.to_sw_sig[0];
    prev_rst   = rst;
  end

  initial begin
    int unsigned e;
    int unsigned e2;
    n_chk     = 0;
    n_fail    = 0;
    fc_model  = '0;
    tog_model = 1'b0;
    rst             = 1'b1;
    bus.to_hw_sig   = 2'b00;
    bus.frame_start = 1'b0;
    set_ports(32'h0);

    tick(2);
    check("reset_words", cur_words(), '0);
    check("reset_to_sw_sig", 320'(bus.to_sw_sig), 320'(2'b00));
    check("reset_busy", 320'(bus.busy), 320'(1'b0));
    check("reset_frame_count", 320'(bus.frame_count), 320'(16'd0));
    rst = 1'b0;
    tick(1);

    // Reserved command leaves the block idle.
    bus.to_hw_sig = 2'b11;
    tick(3);
    check("reserved_busy", 320'(bus.busy), 320'(1'b0));
    bus.to_hw_sig = 2'b00;
    tick(1);

    // Capture aligned to the frame pulse.
    set_ports(32'h1000);
    bus.to_hw_sig = 2'b01;
    tick(1);
    check("wait_busy", 320'(bus.busy), 320'(1'b1));
    tick(4);
    pulse_frame(e);
    expect_commit(mkwords(32'h1000), e + 11);
    wait_until(e + 10);
    check("precommit_words", cur_words(), '0);
    wait_until(e + 12);
    check("capture_ack", 320'(bus.to_sw_sig[0]), 320'(1'b1));
    check("capture_word9", 320'(bus.obj_word9), 320'(32'h1009));
    check("capture_frame_count", 320'(bus.frame_count), 320'(fc_model));
    check("capture_toggle", 320'(bus.to_sw_sig[1]), 320'(tog_model));
    bus.to_hw_sig = 2'b00;
    tick(1);
    check("release_ack", 320'(bus.to_sw_sig[0]), 320'(1'b0));
    check("release_busy", 320'(bus.busy), 320'(1'b0));

    // Abort before the frame pulse, then abort coinciding with the pulse.
    set_ports(32'h5555_0000);
    bus.to_hw_sig = 2'b01;
    tick(3);
    bus.to_hw_sig = 2'b00;
    tick(1);
    check("abort_busy", 320'(bus.busy), 320'(1'b0));
    check("abort_words", cur_words(), mkwords(32'h1000));
    bus.to_hw_sig = 2'b01;
    tick(2);
    bus.to_hw_sig = 2'b00;
    pulse_frame(e);
    tick(12);
    check("abort_race_busy", 320'(bus.busy), 320'(1'b0));
    check("abort_race_words", cur_words(), mkwords(32'h1000));
    check("abort_race_ack", 320'(bus.to_sw_sig[0]), 320'(1'b0));
    check("abort_frame_count", 320'(bus.frame_count), 320'(fc_model));

    // Port change after its word was staged must not reach the committed copy.
    set_ports(32'h2000);
    bus.to_hw_sig = 2'b01;
    tick(1);
    pulse_frame(e);
    expect_commit(mkwords(32'h2000), e + 11);
    wait_until(e + 5);
    bus.to_hw_port3 = 32'h0000_DEAD;
    wait_until(e + 6);
    pulse_frame(e2);
    bus.to_hw_sig = 2'b10;
    wait_until(e + 12);
    check("atomic_word3", 320'(bus.obj_word3), 320'(32'h2003));
    check("atomic_ack", 320'(bus.to_sw_sig[0]), 320'(1'b1));
    check("copy_frame_count", 320'(bus.frame_count), 320'(fc_model));
    check("copy_toggle", 320'(bus.to_sw_sig[1]), 320'(tog_model));
    bus.to_hw_sig = 2'b00;
    tick(1);
    check("atomic_release_busy", 320'(bus.busy), 320'(1'b0));

    // Clear, with the command changing mid-clear and ACK held by a non-idle command.
    issue_sig(2'b10, e);
    expect_commit('0, e + 11);
    wait_until(e + 5);
    bus.to_hw_sig = 2'b01;
    wait_until(e + 12);
    check("clear_words", cur_words(), '0);
    check("clear_ack", 320'(bus.to_sw_sig[0]), 320'(1'b1));
    tick(3);
    check("clear_ack_held", 320'(bus.to_sw_sig[0]), 320'(1'b1));
    bus.to_hw_sig = 2'b00;
    tick(1);
    check("clear_release_ack", 320'(bus.to_sw_sig[0]), 320'(1'b0));

    // Reset at index 5 of a capture discards it.
    set_ports(32'h3000);
    issue_sig(2'b01, e);
    bus.to_hw_sig = 2'b00;
    bus.to_hw_sig = 2'b01;
    pulse_frame(e);
    set_ports(32'h3000);
    wait_until(e + 5);
    rst = 1'b1;
    #1;
    check("async_reset_to_sw_sig", 320'(bus.to_sw_sig), 320'(2'b00));
    check("async_reset_busy", 320'(bus.busy), 320'(1'b0));
    check("async_reset_frame_count", 320'(bus.frame_count), 320'(16'd0));
    fc_model  = '0;
    tog_model = 1'b0;
    bus.to_hw_sig = 2'b00;
    tick(2);
    rst = 1'b0;
    tick(15);
    check("post_reset_words", cur_words(), '0);
    check("post_reset_busy", 320'(bus.busy), 320'(1'b0));
    check("post_reset_ack", 320'(bus.to_sw_sig[0]), 320'(1'b0));

    // Frame counter wrap: 65537 pulses from zero.
    bus.frame_start = 1'b1;
    repeat (65537) @(negedge clk);
    bus.frame_start = 1'b0;
    fc_model  = fc_model + 16'd1;
    tog_model = ~tog_model;
    tick(1);
    check("wrap_frame_count", 320'(bus.frame_count), 320'(16'd1));
    check("wrap_model_count", 320'(bus.frame_count), 320'(fc_model));
    check("wrap_toggle", 320'(bus.to_sw_sig[1]), 320'(1'b1));

    check("pending_commits", 320'(sb_q.size()), 320'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
